// File: rtl/pattern_row_writer.sv
// Streams one DMD pattern per frame request from memory into the row FIFO.
// Define PATTERN_ROW_WRITER_TESTGEN_EN to replace memory data with a counting pattern.
module pattern_row_writer #(
    parameter int WORDS_PER_PATTERN = 6144,
    parameter int NUM_PATTERNS      = 3,
    parameter int MAX_OUTSTANDING   = 8
) (
    input  logic         clk_g,
    input  logic         locked_init_rstz_gq,
    input  logic         mem_preload_done,
    input  logic         mem_read_enable,
    output logic         mem_rd_req,
    output logic [27:0]  mem_rd_addr,
    input  logic         mem_rd_gnt,
    input  logic         mem_rd_valid,
    input  logic [127:0] mem_rd_data,
    output logic         fifo_wr_en,
    output logic [127:0] fifo_din,
    input  logic         fifo_prog_full,
    input  logic         fifo_full,
    output logic         busy,
    output logic         frame_done,
    output logic [3:0]   pattern_idx,
    output logic         missed_req,
    output logic         overflow_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [15:0] WPP      = 16'(WORDS_PER_PATTERN);
    localparam logic [27:0] WPP_ADDR = 28'(WORDS_PER_PATTERN);
    localparam logic [3:0]  LAST_PAT = 4'(NUM_PATTERNS - 1);
    localparam logic [3:0]  MAX_OUT  = 4'(MAX_OUTSTANDING);

    logic [1:0]   state_q, state_d;
    logic [15:0]  rd_cnt_q, rd_cnt_d;
    logic [15:0]  wr_cnt_q, wr_cnt_d;
    logic [3:0]   outst_q, outst_d;
    logic [3:0]   pidx_q, pidx_d;
    logic         en_q, en_d;
    logic         arm_q, arm_d;
    logic         wr_en_q, wr_en_d;
    logic [127:0] din_q, din_d;
    logic         missed_q, missed_d;
    logic         ovf_q, ovf_d;

    logic         rise;
    logic         req;
    logic         rd_step;
    logic         outst_inc;
    logic         outst_dec;
    logic         wr_fire;
    logic [127:0] wr_data;

`ifdef PATTERN_ROW_WRITER_TESTGEN_EN
    logic unused_mem;
    assign unused_mem = ^{mem_rd_gnt, mem_rd_valid, mem_rd_data};
    assign req        = 1'b0;
    assign rd_step    = (state_q == S_FETCH) && (rd_cnt_q < WPP)
                        && !fifo_prog_full;
    assign outst_inc  = 1'b0;
    assign outst_dec  = 1'b0;
    assign wr_fire    = rd_step;
    assign wr_data    = {112'd0, rd_cnt_q + 16'd1};
`else
    assign req        = (state_q == S_FETCH) && (rd_cnt_q < WPP)
                        && (outst_q < MAX_OUT) && !fifo_prog_full;
    assign rd_step    = req && mem_rd_gnt;
    assign outst_inc  = rd_step;
    // Returns with no frame active are stale and must not reach the FIFO.
    assign outst_dec  = mem_rd_valid && (state_q != S_IDLE);
    assign wr_fire    = outst_dec;
    assign wr_data    = mem_rd_data;
`endif

    // Edge detect only arms once the enable has been seen low.
    assign rise = mem_read_enable && !en_q && arm_q;

    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        outst_d  = outst_q;
        pidx_d   = pidx_q;
        en_d     = mem_read_enable;
        arm_d    = arm_q | ~mem_read_enable;
        wr_en_d  = wr_fire;
        din_d    = din_q;
        missed_d = missed_q;
        ovf_d    = ovf_q;

        if (rd_step) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end

        if (outst_inc && !outst_dec) begin
            outst_d = outst_q + 4'd1;
        end else if (outst_dec && !outst_inc && (outst_q != 4'd0)) begin
            outst_d = outst_q - 4'd1;
        end

        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
            din_d    = wr_data;
            if (fifo_full) begin
                ovf_d = 1'b1;
            end
        end

        if (rise && (state_q != S_IDLE)) begin
            missed_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (rise && mem_preload_done) begin
                    state_d  = S_FETCH;
                    rd_cnt_d = 16'd0;
                    wr_cnt_d = 16'd0;
                end
            end
            S_FETCH: begin
                if (rd_cnt_q == WPP) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (wr_cnt_q == WPP) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                pidx_d  = (pidx_q == LAST_PAT) ? 4'd0 : pidx_q + 4'd1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_g or negedge locked_init_rstz_gq) begin
        if (!locked_init_rstz_gq) begin
            state_q  <= S_IDLE;
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
            outst_q  <= 4'd0;
            pidx_q   <= 4'd0;
            en_q     <= 1'b0;
            arm_q    <= 1'b0;
            wr_en_q  <= 1'b0;
            din_q    <= 128'd0;
            missed_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            outst_q  <= outst_d;
            pidx_q   <= pidx_d;
            en_q     <= en_d;
            arm_q    <= arm_d;
            wr_en_q  <= wr_en_d;
            din_q    <= din_d;
            missed_q <= missed_d;
            ovf_q    <= ovf_d;
        end
    end

    assign mem_rd_req   = req;
    assign mem_rd_addr  = (WPP_ADDR * {24'd0, pidx_q}) + {12'd0, rd_cnt_q};
    assign fifo_wr_en   = wr_en_q;
    assign fifo_din     = din_q;
    assign busy         = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign frame_done   = (state_q == S_DONE);
    assign pattern_idx  = pidx_q;
    assign missed_req   = missed_q;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_pattern_row_writer.sv
// Directed frame-level bench for pattern_row_writer with a 3-cycle memory model.
module tb_pattern_row_writer;

    localparam int WPP = 6144;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         preload;
    logic         rd_en;
    logic         mem_rd_req;
    logic [27:0]  mem_rd_addr;
    logic         mem_rd_gnt;
    logic         mem_rd_valid;
    logic [127:0] mem_rd_data;
    logic         fifo_wr_en;
    logic [127:0] fifo_din;
    logic         fifo_prog_full;
    logic         fifo_full;
    logic         busy;
    logic         frame_done;
    logic [3:0]   pattern_idx;
    logic         missed_req;
    logic         overflow_err;

    always #5 clk = ~clk;

    pattern_row_writer dut (
        .clk_g               (clk),
        .locked_init_rstz_gq (rst_n),
        .mem_preload_done    (preload),
        .mem_read_enable     (rd_en),
        .mem_rd_req          (mem_rd_req),
        .mem_rd_addr         (mem_rd_addr),
        .mem_rd_gnt          (mem_rd_gnt),
        .mem_rd_valid        (mem_rd_valid),
        .mem_rd_data         (mem_rd_data),
        .fifo_wr_en          (fifo_wr_en),
        .fifo_din            (fifo_din),
        .fifo_prog_full      (fifo_prog_full),
        .fifo_full           (fifo_full),
        .busy                (busy),
        .frame_done          (frame_done),
        .pattern_idx         (pattern_idx),
        .missed_req          (missed_req),
        .overflow_err        (overflow_err)
    );

    // memory: data = address, valid three cycles after the grant
    logic [2:0]  pv = 3'd0;
    logic [27:0] pd0 = 28'd0, pd1 = 28'd0, pd2 = 28'd0;
    logic        inj_v;

    always @(posedge clk) begin
        pv  <= {pv[1:0], mem_rd_req & mem_rd_gnt};
        pd0 <= mem_rd_addr;
        pd1 <= pd0;
        pd2 <= pd1;
    end

    assign mem_rd_valid = pv[2] | inj_v;
    assign mem_rd_data  = {100'd0, pd2};

    typedef struct {
        int         base;
        logic [3:0] pidx;
        int         hold_at;
        int         miss_at;
        int         full_at;
        logic       missed;
        logic       ovf;
    } frame_vec_t;

    frame_vec_t tbl [7];

    int vecs = 0;
    int errs = 0;

    int          nwr, nbad, nfd, nreq, nreq_hold, nwr_hold;
    int          base_cur;
    logic        hold_on;
    logic        got_addr;
    logic [27:0] first_addr;

    task automatic check(input string name, input longint act,
                         input longint exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr();
        nwr = 0; nbad = 0; nfd = 0; nreq = 0;
        nreq_hold = 0; nwr_hold = 0;
        hold_on = 1'b0; got_addr = 1'b0; first_addr = 28'd0;
    endtask

    task automatic tick();
        logic [127:0] exp_d;
        @(negedge clk);
`ifdef PATTERN_ROW_WRITER_TESTGEN_EN
        exp_d = 128'(longint'(nwr) + 1);
`else
        exp_d = 128'(longint'(base_cur) + longint'(nwr));
`endif
        if (fifo_wr_en) begin
            if (fifo_din !== exp_d) nbad++;
            nwr++;
            if (hold_on) nwr_hold++;
        end
        if (frame_done) nfd++;
        if (mem_rd_req) begin
            nreq++;
            if (hold_on) nreq_hold++;
            if (!got_addr) begin
                got_addr   = 1'b1;
                first_addr = mem_rd_addr;
            end
        end
    endtask

    task automatic pulse();
        rd_en = 1'b1;
        tick();
        tick();
        rd_en = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"},    longint'(mem_rd_req), 0);
        check({tag, "_addr"},   longint'(mem_rd_addr), 0);
        check({tag, "_wr_en"},  longint'(fifo_wr_en), 0);
        check({tag, "_din"},    longint'(fifo_din != 128'd0), 0);
        check({tag, "_busy"},   longint'(busy), 0);
        check({tag, "_fdone"},  longint'(frame_done), 0);
        check({tag, "_pidx"},   longint'(pattern_idx), 0);
        check({tag, "_missed"}, longint'(missed_req), 0);
        check({tag, "_ovf"},    longint'(overflow_err), 0);
    endtask

    task automatic run_frame(input frame_vec_t v, input int id);
        int   n;
        logic hold_done, miss_done, full_done;
        string s;
        s = $sformatf("f%0d", id);
        clr();
        base_cur  = v.base;
        hold_done = 1'b0;
        miss_done = 1'b0;
        full_done = 1'b0;
        pulse();
        n = 0;
        while (nfd == 0 && n < 20000) begin
            tick();
            n++;
            if (v.hold_at >= 0 && !hold_done && nwr >= v.hold_at) begin
                hold_done      = 1'b1;
                fifo_prog_full = 1'b1;
                hold_on        = 1'b1;
                repeat (50) tick();
                fifo_prog_full = 1'b0;
                hold_on        = 1'b0;
            end
            if (v.miss_at >= 0 && !miss_done && nwr >= v.miss_at) begin
                miss_done = 1'b1;
                rd_en     = 1'b1;
                tick();
                rd_en     = 1'b0;
            end
            if (v.full_at >= 0 && !full_done && nwr >= v.full_at) begin
                full_done = 1'b1;
                fifo_full = 1'b1;
                repeat (3) tick();
                fifo_full = 1'b0;
            end
        end
        repeat (5) tick();
        check({s, "_writes"}, longint'(nwr), WPP);
        check({s, "_data"},   longint'(nbad), 0);
        check({s, "_fdone"},  longint'(nfd), 1);
        check({s, "_pidx"},   longint'(pattern_idx), longint'(v.pidx));
        check({s, "_busy"},   longint'(busy), 0);
        check({s, "_missed"}, longint'(missed_req), longint'(v.missed));
        check({s, "_ovf"},    longint'(overflow_err), longint'(v.ovf));
`ifdef PATTERN_ROW_WRITER_TESTGEN_EN
        check({s, "_noreq"},  longint'(nreq), 0);
`else
        check({s, "_base"},   longint'(first_addr), longint'(v.base));
`endif
        if (v.hold_at >= 0) begin
            check({s, "_hold_req"},   longint'(nreq_hold), 0);
            check({s, "_hold_drain"}, longint'(nwr_hold <= 8), 1);
        end
    endtask

    initial begin
        int n;
        frame_vec_t last;

        rst_n = 1'b0; preload = 1'b0; rd_en = 1'b0;
        mem_rd_gnt = 1'b1; fifo_prog_full = 1'b0; fifo_full = 1'b0;
        inj_v = 1'b0; base_cur = 0;
        clr();

        tbl[0] = '{0,     4'd1, -1,   -1,  -1,  1'b0, 1'b0};
        tbl[1] = '{6144,  4'd2, -1,   -1,  -1,  1'b0, 1'b0};
        tbl[2] = '{12288, 4'd0, -1,   -1,  -1,  1'b0, 1'b0};
        tbl[3] = '{0,     4'd1, -1,   -1,  -1,  1'b0, 1'b0};
        tbl[4] = '{6144,  4'd2, 1000, -1,  -1,  1'b0, 1'b0};
        tbl[5] = '{12288, 4'd0, -1,   100, -1,  1'b1, 1'b0};
        tbl[6] = '{0,     4'd1, -1,   -1,  500, 1'b1, 1'b1};
        last   = '{0,     4'd1, -1,   -1,  -1,  1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check_reset_vals("rst0");
        rst_n = 1'b1;
        tick();
        tick();

        // request without preload is ignored silently
        clr();
        pulse();
        repeat (5) tick();
        check("nopre_busy",   longint'(busy), 0);
        check("nopre_missed", longint'(missed_req), 0);
        check("nopre_writes", longint'(nwr), 0);

        // stray return data while idle
        clr();
        inj_v = 1'b1;
        tick();
        tick();
        inj_v = 1'b0;
        repeat (3) tick();
        check("idle_discard", longint'(nwr), 0);

        preload = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_frame(tbl[i], i);
        end

        // reset in the middle of a frame from pattern 1
        clr();
        base_cur = 6144;
        pulse();
        n = 0;
        while (nwr < 3000 && n < 10000) begin
            tick();
            n++;
        end
        check("mid_reached", longint'(nwr), 3000);
        rst_n = 1'b0;
        rd_en = 1'b1;
        #1;
        check_reset_vals("rst1");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clr();
        repeat (10) tick();
        check("held_en_busy",   longint'(busy), 0);
        check("held_en_writes", longint'(nwr), 0);
        rd_en = 1'b0;
        tick();
        run_frame(last, 7);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
